// File: rtl/forest_pkg.sv
// rtl/forest_pkg.sv - shared constants for the Iris random-forest inference core
//
// Purpose: feature/class widths, 64-bit {exponent, fraction} split thresholds
//          and class codes shared by forest_controller and majority_voter.
// Ports:   none (package).

package forest_pkg;

  localparam int FT_W    = 32;
  localparam int CLASS_W = 2;
  localparam int N_TREES = 3;
  localparam int FV_W    = 2 * FT_W;

  // Thresholds in unsigned {integer, binary fraction} fixed point.
  localparam logic [FV_W-1:0] T_2P45 = {32'd2, 32'h7333_3333};
  localparam logic [FV_W-1:0] T_1P75 = {32'd1, 32'hC000_0000};
  localparam logic [FV_W-1:0] T_0P80 = {32'd0, 32'hCCCC_CCCC};
  localparam logic [FV_W-1:0] T_4P95 = {32'd4, 32'hF333_3333};
  localparam logic [FV_W-1:0] T_0P75 = {32'd0, 32'hC000_0000};
  localparam logic [FV_W-1:0] T_5P05 = {32'd5, 32'h0CCC_CCCC};

  localparam logic [CLASS_W-1:0] CLS_SETOSA     = 2'd0;
  localparam logic [CLASS_W-1:0] CLS_VERSICOLOR = 2'd1;
  localparam logic [CLASS_W-1:0] CLS_VIRGINICA  = 2'd2;

endpackage

// File: rtl/forest_majority_voter.sv
// rtl/forest_majority_voter.sv - combinational 3-input majority vote, ties to lowest class
//
// Purpose: returns the class held by at least two inputs; when all three
//          differ, returns the numerically lowest class code.
// Ports:   i_cls0..i_cls2  in  CLASS_W  class votes from the three trees
//          o_voted         out CLASS_W  winning class

module majority_voter
  import forest_pkg::*;
(
  input  logic [CLASS_W-1:0] i_cls0,
  input  logic [CLASS_W-1:0] i_cls1,
  input  logic [CLASS_W-1:0] i_cls2,
  output logic [CLASS_W-1:0] o_voted
);

  logic [CLASS_W-1:0] w_min01;
  logic [CLASS_W-1:0] w_min;

  always_comb begin
    w_min01 = (i_cls0 <= i_cls1) ? i_cls0 : i_cls1;
    w_min   = (w_min01 <= i_cls2) ? w_min01 : i_cls2;
    o_voted = w_min;
    if ((i_cls0 == i_cls1) || (i_cls0 == i_cls2)) begin
      o_voted = i_cls0;
    end else if (i_cls1 == i_cls2) begin
      o_voted = i_cls1;
    end
  end

endmodule

// File: rtl/forest_controller.sv
// rtl/forest_controller.sv - pipelined 3-tree random forest for 4-feature Iris vectors
//
// Purpose: evaluates three fixed decision trees on every sampled feature
//          vector (stage 1), majority-votes the registered tree results
//          (stage 2). One vector per clock, result two rising edges later.
// Ports:   clock                       in   1   rising-edge clock
//          reset_n                     in   1   asynchronous active-low reset
//          ftN_exponent / ftN_fraction in   32  feature N = {integer, fraction}, N=0..3
//          voted                       out  2   registered majority class

module forest_controller
  import forest_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic [FT_W-1:0]    ft0_exponent,
  input  logic [FT_W-1:0]    ft0_fraction,
  input  logic [FT_W-1:0]    ft1_exponent,
  input  logic [FT_W-1:0]    ft1_fraction,
  input  logic [FT_W-1:0]    ft2_exponent,
  input  logic [FT_W-1:0]    ft2_fraction,
  input  logic [FT_W-1:0]    ft3_exponent,
  input  logic [FT_W-1:0]    ft3_fraction,
  output logic [CLASS_W-1:0] voted
);

  logic [FV_W-1:0]    w_ft2;
  logic [FV_W-1:0]    w_ft3;
  logic [CLASS_W-1:0] w_tree0;
  logic [CLASS_W-1:0] w_tree1;
  logic [CLASS_W-1:0] w_tree2;
  logic [CLASS_W-1:0] w_vote;
  logic               w_unused_ft;

  logic [CLASS_W-1:0] r_cls0;
  logic [CLASS_W-1:0] r_cls1;
  logic [CLASS_W-1:0] r_cls2;
  logic [CLASS_W-1:0] r_voted;

  // Sepal features never reach a split in these trees.
  assign w_unused_ft = ^{ft0_exponent, ft0_fraction, ft1_exponent, ft1_fraction};

  assign w_ft2 = {ft2_exponent, ft2_fraction};
  assign w_ft3 = {ft3_exponent, ft3_fraction};

  // All splits are inclusive "<=" over the full 64-bit fixed-point value.
  always_comb begin
    w_tree0 = CLS_SETOSA;
    w_tree1 = CLS_SETOSA;
    w_tree2 = CLS_SETOSA;

    if (w_ft2 > T_2P45) begin
      w_tree0 = (w_ft3 <= T_1P75) ? CLS_VERSICOLOR : CLS_VIRGINICA;
    end
    if (w_ft3 > T_0P80) begin
      w_tree1 = (w_ft2 <= T_4P95) ? CLS_VERSICOLOR : CLS_VIRGINICA;
    end
    if (w_ft3 > T_0P75) begin
      w_tree2 = (w_ft2 <= T_5P05) ? CLS_VERSICOLOR : CLS_VIRGINICA;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cls0 <= CLS_SETOSA;
      r_cls1 <= CLS_SETOSA;
      r_cls2 <= CLS_SETOSA;
    end else begin
      r_cls0 <= w_tree0;
      r_cls1 <= w_tree1;
      r_cls2 <= w_tree2;
    end
  end

  majority_voter u_voter (
    .i_cls0  (r_cls0),
    .i_cls1  (r_cls1),
    .i_cls2  (r_cls2),
    .o_voted (w_vote)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_voted <= CLS_SETOSA;
    end else begin
      r_voted <= w_vote;
    end
  end

  assign voted = r_voted;

endmodule

// File: tb/tb_forest_controller.sv
// tb/tb_forest_controller.sv - self-checking bench for forest_controller

module tb_forest_controller;

  logic        clock;
  logic        reset_n;
  logic [31:0] ft0_exponent, ft0_fraction;
  logic [31:0] ft1_exponent, ft1_fraction;
  logic [31:0] ft2_exponent, ft2_fraction;
  logic [31:0] ft3_exponent, ft3_fraction;
  logic [1:0]  voted;

  logic [1:0]  v_a, v_b, v_c, v_out;

  int checks = 0;
  int errors = 0;

  forest_controller dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .ft0_exponent (ft0_exponent),
    .ft0_fraction (ft0_fraction),
    .ft1_exponent (ft1_exponent),
    .ft1_fraction (ft1_fraction),
    .ft2_exponent (ft2_exponent),
    .ft2_fraction (ft2_fraction),
    .ft3_exponent (ft3_exponent),
    .ft3_fraction (ft3_fraction),
    .voted        (voted)
  );

  majority_voter u_vote_chk (
    .i_cls0  (v_a),
    .i_cls1  (v_b),
    .i_cls2  (v_c),
    .o_voted (v_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] ft2;
    logic [63:0] ft3;
    logic [1:0]  exp_voted;
    string       name;
  } vec_t;

  typedef struct {
    logic [1:0] a, b, c, exp_v;
  } vote_vec_t;

  vec_t      vecs[11];
  vote_vec_t vvecs[10];

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: voted=%0d expected=%0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference trees written directly from the split thresholds in decimal fixed point.
  function automatic logic [1:0] golden(input logic [63:0] f2, input logic [63:0] f3);
    int n[3];
    logic [1:0] t0, t1, t2;
    t0 = (f2 <= 64'h0000_0002_7333_3333) ? 2'd0 : ((f3 <= 64'h0000_0001_C000_0000) ? 2'd1 : 2'd2);
    t1 = (f3 <= 64'h0000_0000_CCCC_CCCC) ? 2'd0 : ((f2 <= 64'h0000_0004_F333_3333) ? 2'd1 : 2'd2);
    t2 = (f3 <= 64'h0000_0000_C000_0000) ? 2'd0 : ((f2 <= 64'h0000_0005_0CCC_CCCC) ? 2'd1 : 2'd2);
    n[0] = 0; n[1] = 0; n[2] = 0;
    n[t0]++; n[t1]++; n[t2]++;
    if (n[0] >= n[1] && n[0] >= n[2]) return 2'd0;
    if (n[1] >= n[2]) return 2'd1;
    return 2'd2;
  endfunction

  task automatic drive(input logic [63:0] f2, input logic [63:0] f3);
    ft0_exponent = $urandom_range(4, 8);
    ft0_fraction = $urandom;
    ft1_exponent = $urandom_range(2, 4);
    ft1_fraction = $urandom;
    {ft2_exponent, ft2_fraction} = f2;
    {ft3_exponent, ft3_fraction} = f3;
  endtask

  logic [1:0]  p1, p2;
  logic [63:0] rf2, rf3;

  initial begin
    vecs[0]  = '{ {32'd1, 32'h6666_6666}, {32'd0, 32'h3333_3333}, 2'd0, "setosa" };
    vecs[1]  = '{ {32'd4, 32'hB333_3333}, {32'd1, 32'h6666_6666}, 2'd1, "versicolor" };
    vecs[2]  = '{ {32'd6, 32'h0000_0000}, {32'd2, 32'h8000_0000}, 2'd2, "virginica" };
    vecs[3]  = '{ {32'd2, 32'h7333_3333}, {32'd0, 32'h3333_3333}, 2'd0, "ft2_eq_2p45" };
    vecs[4]  = '{ {32'd2, 32'h7333_3334}, {32'd1, 32'h8000_0000}, 2'd1, "ft2_above_2p45" };
    vecs[5]  = '{ {32'd5, 32'h0000_0000}, {32'd1, 32'h8000_0000}, 2'd1, "disagree_121" };
    vecs[6]  = '{ {32'd5, 32'h0000_0000}, {32'd0, 32'hCCCC_CCCC}, 2'd1, "ft3_eq_0p80" };
    vecs[7]  = '{ {32'd5, 32'h1999_9999}, {32'd0, 32'hC000_0000}, 2'd0, "ft3_eq_0p75" };
    vecs[8]  = '{ {32'd5, 32'h0CCC_CCCC}, {32'd1, 32'hC000_0000}, 2'd1, "ft2_eq_5p05" };
    vecs[9]  = '{ {32'd5, 32'h0CCC_CCCD}, {32'd1, 32'hC000_0001}, 2'd2, "above_5p05_1p75" };
    vecs[10] = '{ {32'hFFFF_FFFF, 32'h0}, {32'd0, 32'h0000_0000}, 2'd0, "ft2_huge_exp" };

    vvecs[0] = '{2'd0, 2'd1, 2'd2, 2'd0};
    vvecs[1] = '{2'd2, 2'd1, 2'd0, 2'd0};
    vvecs[2] = '{2'd2, 2'd0, 2'd1, 2'd0};
    vvecs[3] = '{2'd1, 2'd2, 2'd3, 2'd1};
    vvecs[4] = '{2'd3, 2'd2, 2'd1, 2'd1};
    vvecs[5] = '{2'd1, 2'd1, 2'd2, 2'd1};
    vvecs[6] = '{2'd2, 2'd0, 2'd2, 2'd2};
    vvecs[7] = '{2'd3, 2'd3, 2'd0, 2'd3};
    vvecs[8] = '{2'd0, 2'd2, 2'd2, 2'd2};
    vvecs[9] = '{2'd3, 2'd1, 2'd2, 2'd1};

    // Reset state, with virginica inputs present to show they are ignored.
    reset_n = 1'b0;
    drive({32'd6, 32'h0}, {32'd2, 32'h8000_0000});
    v_a = 2'd0; v_b = 2'd0; v_c = 2'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_state", voted, 2'd0);
    reset_n = 1'b1;

    // Directed vectors: apply, wait two edges, sample on the falling edge.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].ft2, vecs[i].ft3);
      @(posedge clock);
      @(posedge clock);
      @(negedge clock);
      check(vecs[i].name, voted, vecs[i].exp_voted);
    end

    // Voter tie rule and plain majorities, including class code 3.
    for (int i = 0; i < 10; i++) begin
      v_a = vvecs[i].a; v_b = vvecs[i].b; v_c = vvecs[i].c;
      #1;
      check($sformatf("voter_%0d%0d%0d", v_a, v_b, v_c), v_out, vvecs[i].exp_v);
    end

    // Exact latency: setosa steady, switch to virginica, result must not move early.
    drive({32'd1, 32'h6666_6666}, {32'd0, 32'h3333_3333});
    repeat (2) @(posedge clock);
    @(negedge clock);
    drive({32'd6, 32'h0}, {32'd2, 32'h8000_0000});
    @(posedge clock); @(negedge clock);
    check("latency_edge1", voted, 2'd0);
    @(posedge clock); @(negedge clock);
    check("latency_edge2", voted, 2'd2);

    // Back-to-back stream of 150 vectors with a mid-stream reset.
    p1 = 2'd2; p2 = 2'd2;
    for (int i = 0; i < 150; i++) begin
      rf2 = {29'd0, 3'($urandom_range(0, 7)), 32'($urandom)};
      rf3 = {30'd0, 2'($urandom_range(0, 2)), 32'($urandom)};
      if (i % 17 == 3) rf2 = 64'h0000_0004_F333_3333;
      if (i % 19 == 5) rf3 = 64'h0000_0000_C000_0000;
      drive(rf2, rf3);
      if (i == 75) begin
        reset_n = 1'b0;
        #1;
        check("reset_async", voted, 2'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_hold", voted, 2'd0);
        p1 = 2'd0; p2 = 2'd0;
        reset_n = 1'b1;
      end
      @(posedge clock);
      p2 = p1;
      p1 = golden(rf2, rf3);
      @(negedge clock);
      check($sformatf("stream_%0d", i), voted, p2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
